// File: rtl/rv_ahb_sram_slave.sv
// AHB-Lite responder for a word-organised SRAM with byte-lane writes and a two-cycle ERROR response.
// Data phase takes WAIT_STATES+1 cycles (errors take 2); HREADYOUT low stalls the bus.
module rv_ahb_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_lo;
    logic              cap_write;
    logic [2:0]        cap_size;
    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              aligned;
    logic              legal;
    logic [3:0]        lane_en;
    logic              unused_haddr;

    // Upper address bits alias onto the same words; HTRANS[0] only separates NONSEQ/SEQ.
    assign unused_haddr = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

    // Stalled states never look at the address phase.
    assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;

    always_comb begin
        case (HSIZE)
            3'd1:    aligned = ~HADDR[0];
            3'd2:    aligned = (HADDR[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign legal = (HSIZE <= 3'd2) & aligned;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_LAST;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (accept && !legal) begin
                    state_nxt = ST_ERR1;
                end else if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WS_M1;
                    end else begin
                        state_nxt = ST_LAST;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_lo    <= '0;
            cap_write <= 1'b0;
            cap_size  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_addr  <= HADDR[ADDR_W+1:2];
                cap_lo    <= HADDR[1:0];
                cap_write <= HWRITE;
                cap_size  <= HSIZE;
            end
        end
    end

    // Only legal transfers reach LAST, so sizes above word never appear here.
    always_comb begin
        case (cap_size)
            3'd0:    lane_en = 4'b0001 << cap_lo;
            3'd1:    lane_en = cap_lo[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Write lands on the completing edge; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (rst_n && (state == ST_LAST) && cap_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[cap_addr][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign HRDATA    = (state == ST_LAST) ? mem[cap_addr] : 32'd0;

endmodule
